// File: rtl/conv_layer_mem_pkg.sv
// Shared constants, selectors and state types for the CONV memory responder.
package conv_mem_pkg;

    localparam int unsigned DW        = 20;
    localparam int unsigned AW        = 12;
    localparam int unsigned IMG_DEPTH = 4096;
    localparam int unsigned L0_DEPTH  = 4096;
    localparam int unsigned L1_DEPTH  = 1024;

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    typedef enum logic [1:0] {
        HSEL_IMG = 2'd0,
        HSEL_L0  = 2'd1,
        HSEL_L1  = 2'd2
    } hsel_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Which bank a registered CONV layer read returns from
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_L0   = 2'd1,
        SRC_L1   = 2'd2
    } rd_src_t;

    function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/conv_layer_mem_if.sv
// Host load/readback port of the CONV memory responder.
interface conv_layer_mem_if #(
    parameter int unsigned DW = conv_mem_pkg::DW,
    parameter int unsigned AW = conv_mem_pkg::AW
);
    logic          h_we;
    logic          h_re;
    logic [1:0]    h_sel;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic [DW-1:0] h_rdata;
    logic          h_rvalid;
    logic          h_err;

    modport master (
        output h_we, h_re, h_sel, h_addr, h_wdata,
        input  h_rdata, h_rvalid, h_err
    );

    modport slave (
        input  h_we, h_re, h_sel, h_addr, h_wdata,
        output h_rdata, h_rvalid, h_err
    );
endinterface

// File: rtl/conv_layer_mem_bank.sv
// Single-clock memory bank: one write port, one registered read-first read port.
module conv_mem_bank #(
    parameter int unsigned DW    = 20,
    parameter int unsigned DEPTH = 4096,
    localparam int unsigned IW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [IW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    // Write and read share an edge; the read samples the pre-write contents
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/conv_layer_mem.sv
// CONV memory-side responder: image bank, layer-0 / layer-1 banks, host port, run status.
module conv_layer_mem #(
    parameter int unsigned DW        = conv_mem_pkg::DW,
    parameter int unsigned AW        = conv_mem_pkg::AW,
    parameter int unsigned IMG_DEPTH = conv_mem_pkg::IMG_DEPTH,
    parameter int unsigned L0_DEPTH  = conv_mem_pkg::L0_DEPTH,
    parameter int unsigned L1_DEPTH  = conv_mem_pkg::L1_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          busy,
    input  logic          ready,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel,
    conv_layer_mem_if.slave host,
    output logic          l0_written,
    output logic          l1_written,
    output logic          run_done,
    output logic          addr_err,
    output logic          csel_err
);
    import conv_mem_pkg::*;

    localparam int unsigned IMG_IW = $clog2(IMG_DEPTH);
    localparam int unsigned L0_IW  = $clog2(L0_DEPTH);
    localparam int unsigned L1_IW  = $clog2(L1_DEPTH);

    state_t        state_q, state_d;
    logic          busy_q, busy_rise, busy_fall, host_ok;
    logic          sel_l0, sel_l1, wr_inr, rd_inr, img_inr, h_inr;
    logic          img_rd_c, l0_cwe, l1_cwe, l0_cre, l1_cre;
    logic          h_req, h_acc, aerr_set, cerr_set;
    logic          h_img_rd, h_l0_rd, h_l1_rd;
    logic          img_v_q, crd_q, h_rvalid_q, h_err_q;
    rd_src_t       c_src_q, c_src_d;
    hsel_t         h_src_q;
    logic [DW-1:0] c_hold_q, h_hold_q, h_rdata_c;
    logic [DW-1:0] img_rdata, l0_rdata, l1_rdata;

    // Request decode for the CONV ports and the host port
    always_comb begin
        busy_rise = busy & ~busy_q;
        busy_fall = ~busy & busy_q;
        sel_l0    = (csel == CSEL_L0);
        sel_l1    = (csel == CSEL_L1);
        wr_inr    = in_range(32'(caddr_wr), sel_l1 ? L1_DEPTH : L0_DEPTH);
        rd_inr    = in_range(32'(caddr_rd), sel_l1 ? L1_DEPTH : L0_DEPTH);
        img_inr   = in_range(32'(iaddr), IMG_DEPTH);
        img_rd_c  = busy & ~ready & img_inr;
        l0_cwe    = cwr & sel_l0 & wr_inr;
        l1_cwe    = cwr & sel_l1 & wr_inr;
        l0_cre    = crd & sel_l0 & rd_inr;
        l1_cre    = crd & sel_l1 & rd_inr;
        cerr_set  = (cwr | crd) & ~(sel_l0 | sel_l1);
        aerr_set  = (cwr & (sel_l0 | sel_l1) & ~wr_inr) |
                    (crd & (sel_l0 | sel_l1) & ~rd_inr) |
                    (busy & ~ready & ~img_inr);
        c_src_d   = l0_cre ? SRC_L0 : (l1_cre ? SRC_L1 : SRC_NONE);
        case (host.h_sel)
            HSEL_IMG: h_inr = in_range(32'(host.h_addr), IMG_DEPTH);
            HSEL_L0:  h_inr = in_range(32'(host.h_addr), L0_DEPTH);
            HSEL_L1:  h_inr = in_range(32'(host.h_addr), L1_DEPTH);
            default:  h_inr = 1'b0;
        endcase
        h_req    = host.h_we | host.h_re;
        h_acc    = h_req & host_ok & h_inr;
        h_img_rd = h_acc & host.h_re & (host.h_sel == HSEL_IMG);
        h_l0_rd  = h_acc & host.h_re & (host.h_sel == HSEL_L0);
        h_l1_rd  = h_acc & host.h_re & (host.h_sel == HSEL_L1);
    end

    // Host-port FSM next state; host is also held off whenever CONV drives a
    // port, so the first cycle of a run (state still IDLE) stays exclusive
    always_comb begin
        state_d = state_q;
        host_ok = 1'b0;
        case (state_q)
            IDLE: begin
                host_ok = ~busy & ~cwr & ~crd;
                if (busy_q) state_d = RUN;
            end
            RUN:     if (!busy_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state and previous-busy registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy;
        end
    end

    // Read-return tracking; holds keep outputs stable between fresh reads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            img_v_q    <= 1'b0;
            crd_q      <= 1'b0;
            c_src_q    <= SRC_NONE;
            c_hold_q   <= '0;
            h_rvalid_q <= 1'b0;
            h_err_q    <= 1'b0;
            h_src_q    <= HSEL_IMG;
            h_hold_q   <= '0;
        end else begin
            img_v_q    <= img_rd_c;
            crd_q      <= crd;
            c_src_q    <= c_src_d;
            c_hold_q   <= cdata_rd;
            h_rvalid_q <= h_acc & host.h_re;
            h_err_q    <= h_req & ~h_acc;
            if (h_acc && host.h_re) h_src_q <= hsel_t'(host.h_sel);
            h_hold_q   <= h_rdata_c;
        end
    end

    // Run status: sticky flags cleared at run start, set dominates the clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_done   <= 1'b0;
            l0_written <= 1'b0;
            l1_written <= 1'b0;
            addr_err   <= 1'b0;
            csel_err   <= 1'b0;
        end else begin
            run_done   <= busy_fall;
            l0_written <= l0_cwe   | (l0_written & ~busy_rise);
            l1_written <= l1_cwe   | (l1_written & ~busy_rise);
            addr_err   <= aerr_set | (addr_err   & ~busy_rise);
            csel_err   <= cerr_set | (csel_err   & ~busy_rise);
        end
    end

    // Output data muxing from the bank read registers
    always_comb begin
        idata    = img_v_q ? img_rdata : '0;
        cdata_rd = c_hold_q;
        if (crd_q) begin
            case (c_src_q)
                SRC_L0:  cdata_rd = l0_rdata;
                SRC_L1:  cdata_rd = l1_rdata;
                default: cdata_rd = '0;
            endcase
        end
        h_rdata_c = h_hold_q;
        if (h_rvalid_q) begin
            case (h_src_q)
                HSEL_IMG: h_rdata_c = img_rdata;
                HSEL_L0:  h_rdata_c = l0_rdata;
                default:  h_rdata_c = l1_rdata;
            endcase
        end
    end

    assign host.h_rdata  = h_rdata_c;
    assign host.h_rvalid = h_rvalid_q;
    assign host.h_err    = h_err_q;

    conv_mem_bank #(.DW(DW), .DEPTH(IMG_DEPTH)) u_img (
        .clk   (clk),
        .we    (h_acc & host.h_we & (host.h_sel == HSEL_IMG)),
        .waddr (host.h_addr[IMG_IW-1:0]),
        .wdata (host.h_wdata),
        .re    (img_rd_c | h_img_rd),
        .raddr (img_rd_c ? iaddr[IMG_IW-1:0] : host.h_addr[IMG_IW-1:0]),
        .rdata (img_rdata)
    );

    conv_mem_bank #(.DW(DW), .DEPTH(L0_DEPTH)) u_l0 (
        .clk   (clk),
        .we    (l0_cwe | (h_acc & host.h_we & (host.h_sel == HSEL_L0))),
        .waddr (l0_cwe ? caddr_wr[L0_IW-1:0] : host.h_addr[L0_IW-1:0]),
        .wdata (l0_cwe ? cdata_wr : host.h_wdata),
        .re    (l0_cre | h_l0_rd),
        .raddr (l0_cre ? caddr_rd[L0_IW-1:0] : host.h_addr[L0_IW-1:0]),
        .rdata (l0_rdata)
    );

    conv_mem_bank #(.DW(DW), .DEPTH(L1_DEPTH)) u_l1 (
        .clk   (clk),
        .we    (l1_cwe | (h_acc & host.h_we & (host.h_sel == HSEL_L1))),
        .waddr (l1_cwe ? caddr_wr[L1_IW-1:0] : host.h_addr[L1_IW-1:0]),
        .wdata (l1_cwe ? cdata_wr : host.h_wdata),
        .re    (l1_cre | h_l1_rd),
        .raddr (l1_cre ? caddr_rd[L1_IW-1:0] : host.h_addr[L1_IW-1:0]),
        .rdata (l1_rdata)
    );
endmodule

// File: tb/tb_conv_layer_mem.sv
// Self-checking bench for conv_layer_mem: directed vectors plus randomized traffic vs a reference model.
module tb_conv_layer_mem;
    import conv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy, ready, cwr, crd;
    logic [11:0] iaddr, caddr_wr, caddr_rd;
    logic [19:0] cdata_wr, idata, cdata_rd;
    logic [2:0]  csel;
    logic        l0_written, l1_written, run_done, addr_err, csel_err;

    conv_layer_mem_if #(.DW(20), .AW(12)) hif ();

    conv_layer_mem #(
        .DW(20), .AW(12), .IMG_DEPTH(4096), .L0_DEPTH(4096), .L1_DEPTH(1024)
    ) dut (
        .clk(clk), .reset(reset), .busy(busy), .ready(ready),
        .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
        .host(hif),
        .l0_written(l0_written), .l1_written(l1_written), .run_done(run_done),
        .addr_err(addr_err), .csel_err(csel_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference memories and flag state
    logic [19:0] img_m [4096];
    logic [19:0] l0_m  [4096];
    logic [19:0] l1_m  [1024];
    logic        m_l0w, m_l1w, m_ae, m_ce;
    logic [19:0] exp_cd;

    typedef struct {
        logic        cwr;
        logic        crd;
        logic [2:0]  csel;
        logic [11:0] wa;
        logic [19:0] wd;
        logic [11:0] ra;
        logic [19:0] cd;
        logic        l0w, l1w, ae, ce;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int dep(input int sel);
        case (sel)
            0, 1:    return 4096;
            2:       return 1024;
            default: return 0;
        endcase
    endfunction

    function automatic logic [19:0] mread(input int sel, input int a);
        case (sel)
            0:       return img_m[a];
            1:       return l0_m[a];
            default: return l1_m[a];
        endcase
    endfunction

    task automatic mwrite(input int sel, input int a, input logic [19:0] d);
        case (sel)
            0:       img_m[a] = d;
            1:       l0_m[a]  = d;
            default: l1_m[a]  = d;
        endcase
    endtask

    function automatic int pick_addr(input int sel);
        if (sel == 1) return $urandom_range(0, 15);
        if ($urandom_range(0, 1) == 1) return $urandom_range(0, 15);
        return $urandom_range(1016, 1031);
    endfunction

    task automatic host_wr(input int sel, input int a, input logic [19:0] d);
        hif.h_we = 1'b1; hif.h_re = 1'b0;
        hif.h_sel = 2'(sel); hif.h_addr = 12'(a); hif.h_wdata = d;
        mwrite(sel, a, d);
        cyc();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_idata"},    32'(idata),        0);
        chk({tag, "_cdata_rd"}, 32'(cdata_rd),     0);
        chk({tag, "_h_rdata"},  32'(hif.h_rdata),  0);
        chk({tag, "_h_rvalid"}, 32'(hif.h_rvalid), 0);
        chk({tag, "_h_err"},    32'(hif.h_err),    0);
        chk({tag, "_run_done"}, 32'(run_done),     0);
        chk({tag, "_l0w"},      32'(l0_written),   0);
        chk({tag, "_l1w"},      32'(l1_written),   0);
        chk({tag, "_addr_err"}, 32'(addr_err),     0);
        chk({tag, "_csel_err"}, 32'(csel_err),     0);
    endtask

    initial begin
        reset = 1'b0; busy = 1'b0; ready = 1'b0; cwr = 1'b0; crd = 1'b0;
        iaddr = '0; caddr_wr = '0; caddr_rd = '0; cdata_wr = '0; csel = '0;
        hif.h_we = 1'b0; hif.h_re = 1'b0; hif.h_sel = '0; hif.h_addr = '0; hif.h_wdata = '0;

        //             cwr crd csel     wa         wd        ra         cd        l0w l1w ae ce
        tbl[0]  = '{1'b1, 1'b0, CSEL_L0, 12'd5,    20'hABCDE, 12'd0,    20'h00000, 1, 0, 0, 0};
        tbl[1]  = '{1'b0, 1'b1, CSEL_L0, 12'd0,    20'h0,     12'd5,    20'hABCDE, 1, 0, 0, 0};
        tbl[2]  = '{1'b1, 1'b0, CSEL_L1, 12'd7,    20'h22222, 12'd0,    20'hABCDE, 1, 1, 0, 0};
        tbl[3]  = '{1'b1, 1'b0, CSEL_L1, 12'd0,    20'h44444, 12'd0,    20'hABCDE, 1, 1, 0, 0};
        tbl[4]  = '{1'b1, 1'b0, CSEL_L1, 12'd3,    20'h55555, 12'd0,    20'hABCDE, 1, 1, 0, 0};
        tbl[5]  = '{1'b1, 1'b1, CSEL_L1, 12'd7,    20'h11111, 12'd7,    20'h22222, 1, 1, 0, 0};
        tbl[6]  = '{1'b0, 1'b1, CSEL_L1, 12'd0,    20'h0,     12'd7,    20'h11111, 1, 1, 0, 0};
        tbl[7]  = '{1'b1, 1'b0, CSEL_L1, 12'd1024, 20'h33333, 12'd0,    20'h11111, 1, 1, 1, 0};
        tbl[8]  = '{1'b0, 1'b1, CSEL_L1, 12'd0,    20'h0,     12'd0,    20'h44444, 1, 1, 1, 0};
        tbl[9]  = '{1'b0, 1'b1, 3'b010,  12'd0,    20'h0,     12'd5,    20'h00000, 1, 1, 1, 1};
        tbl[10] = '{1'b0, 1'b1, CSEL_L1, 12'd0,    20'h0,     12'd0,    20'h44444, 1, 1, 1, 1};
        tbl[11] = '{1'b0, 1'b1, CSEL_L1, 12'd0,    20'h0,     12'd2000, 20'h00000, 1, 1, 1, 1};
        tbl[12] = '{1'b0, 1'b1, CSEL_L0, 12'd0,    20'h0,     12'd5,    20'hABCDE, 1, 1, 1, 1};

        // Reset state
        repeat (3) cyc();
        chk_all_zero("reset");
        reset = 1'b1;
        cyc();

        // Host preload: image ramp and small known windows of L0/L1
        for (int a = 0; a < 4096; a++) host_wr(0, a, 20'(a * 3));
        for (int a = 0; a < 16; a++) host_wr(1, a, 20'($urandom));
        for (int a = 0; a < 16; a++) host_wr(2, a, 20'($urandom));
        for (int a = 1016; a < 1024; a++) host_wr(2, a, 20'($urandom));
        hif.h_we = 1'b0;
        cyc();

        // Random idle-time host traffic against the model
        for (int n = 0; n < 200; n++) begin
            int sel, a;
            logic we, re, ok, erv;
            logic [19:0] d, erd;
            sel = $urandom_range(0, 3);
            we  = (sel != 0) && ($urandom_range(0, 1) == 1);
            re  = ($urandom_range(0, 1) == 1);
            a   = (sel == 0 || sel == 3) ? $urandom_range(0, 4095) : pick_addr(sel);
            d   = 20'($urandom);
            ok  = (sel != 3) && (a < dep(sel));
            erv = re && ok;
            erd = erv ? mread(sel, a) : '0;
            if (we && ok) mwrite(sel, a, d);
            hif.h_we = we; hif.h_re = re; hif.h_sel = 2'(sel);
            hif.h_addr = 12'(a); hif.h_wdata = d;
            cyc();
            chk("host_rnd_err", 32'(hif.h_err), 32'((we || re) && !ok));
            chk("host_rnd_rvalid", 32'(hif.h_rvalid), 32'(erv));
            if (erv) chk("host_rnd_rdata", 32'(hif.h_rdata), 32'(erd));
        end
        hif.h_we = 1'b0; hif.h_re = 1'b0;
        cyc();

        // Image sweep during a run
        busy = 1'b1; ready = 1'b0;
        cyc();
        for (int a = 0; a < 4096; a++) begin
            iaddr = 12'(a);
            cyc();
            chk("idata_sweep", 32'(idata), 32'(img_m[a]));
        end
        ready = 1'b1;
        cyc();
        chk("idata_ready_gate", 32'(idata), 0);

        // Host access during a run is rejected
        hif.h_re = 1'b1; hif.h_sel = 2'd2; hif.h_addr = 12'd3;
        cyc();
        chk("run_host_err", 32'(hif.h_err), 1);
        chk("run_host_rvalid", 32'(hif.h_rvalid), 0);
        hif.h_re = 1'b0;
        cyc();
        chk("run_host_err_pulse", 32'(hif.h_err), 0);

        // Directed layer-port vectors
        for (int i = 0; i < 13; i++) begin
            cwr = tbl[i].cwr; crd = tbl[i].crd; csel = tbl[i].csel;
            caddr_wr = tbl[i].wa; cdata_wr = tbl[i].wd; caddr_rd = tbl[i].ra;
            cyc();
            chk($sformatf("vec%0d_cdata", i), 32'(cdata_rd), 32'(tbl[i].cd));
            chk($sformatf("vec%0d_l0w", i), 32'(l0_written), 32'(tbl[i].l0w));
            chk($sformatf("vec%0d_l1w", i), 32'(l1_written), 32'(tbl[i].l1w));
            chk($sformatf("vec%0d_aerr", i), 32'(addr_err), 32'(tbl[i].ae));
            chk($sformatf("vec%0d_cerr", i), 32'(csel_err), 32'(tbl[i].ce));
            if (tbl[i].cwr && tbl[i].csel == CSEL_L0 && tbl[i].wa < 12'd4096) l0_m[tbl[i].wa] = tbl[i].wd;
            if (tbl[i].cwr && tbl[i].csel == CSEL_L1 && tbl[i].wa < 12'd1024) l1_m[tbl[i].wa] = tbl[i].wd;
        end
        exp_cd = tbl[12].cd;
        cwr = 1'b0; crd = 1'b0;

        // Run end: run_done pulse, flags stay sticky, host reads back
        busy = 1'b0;
        cyc();
        chk("run_done_pulse", 32'(run_done), 1);
        cyc();
        chk("run_done_clear", 32'(run_done), 0);
        chk("aerr_sticky", 32'(addr_err), 1);
        chk("cerr_sticky", 32'(csel_err), 1);
        chk("cdata_hold", 32'(cdata_rd), 32'(exp_cd));
        hif.h_re = 1'b1; hif.h_sel = 2'd2; hif.h_addr = 12'd3;
        cyc();
        chk("host_l1_rvalid", 32'(hif.h_rvalid), 1);
        chk("host_l1_rdata", 32'(hif.h_rdata), 32'h55555);
        hif.h_re = 1'b0;
        cyc();
        chk("host_rvalid_pulse", 32'(hif.h_rvalid), 0);

        // New run start clears sticky flags
        busy = 1'b1;
        cyc();
        chk("rise_l0w", 32'(l0_written), 0);
        chk("rise_l1w", 32'(l1_written), 0);
        chk("rise_aerr", 32'(addr_err), 0);
        chk("rise_cerr", 32'(csel_err), 0);
        m_l0w = 1'b0; m_l1w = 1'b0; m_ae = 1'b0; m_ce = 1'b0;

        // Random CONV traffic during a run
        for (int n = 0; n < 600; n++) begin
            int r, sel, wa, ra;
            logic [2:0]  cs;
            logic        w, rd, rdy, hre;
            logic [19:0] wd, exp_id;
            logic [11:0] ia;
            r   = $urandom_range(0, 9);
            cs  = (r < 4) ? CSEL_L0 : (r < 8) ? CSEL_L1 : (r == 8) ? 3'b010 : 3'b111;
            sel = (cs == CSEL_L0) ? 1 : (cs == CSEL_L1) ? 2 : 3;
            w   = ($urandom_range(0, 1) == 1);
            rd  = ($urandom_range(0, 1) == 1);
            wa  = pick_addr(sel);
            ra  = pick_addr(sel);
            wd  = 20'($urandom);
            rdy = ($urandom_range(0, 3) == 0);
            ia  = 12'($urandom);
            hre = ($urandom_range(0, 7) == 0);
            if (rd) begin
                if (sel == 3) begin exp_cd = '0; m_ce = 1'b1; end
                else if (ra >= dep(sel)) begin exp_cd = '0; m_ae = 1'b1; end
                else exp_cd = mread(sel, ra);
            end
            if (w) begin
                if (sel == 3) m_ce = 1'b1;
                else if (wa >= dep(sel)) m_ae = 1'b1;
                else begin
                    mwrite(sel, wa, wd);
                    if (sel == 1) m_l0w = 1'b1; else m_l1w = 1'b1;
                end
            end
            exp_id = rdy ? 20'h0 : img_m[ia];
            cwr = w; crd = rd; csel = cs; caddr_wr = 12'(wa); caddr_rd = 12'(ra);
            cdata_wr = wd; ready = rdy; iaddr = ia;
            hif.h_re = hre; hif.h_sel = 2'd1; hif.h_addr = 12'd0;
            cyc();
            chk("rnd_cdata", 32'(cdata_rd), 32'(exp_cd));
            chk("rnd_idata", 32'(idata), 32'(exp_id));
            chk("rnd_h_err", 32'(hif.h_err), 32'(hre));
            chk("rnd_l0w", 32'(l0_written), 32'(m_l0w));
            chk("rnd_l1w", 32'(l1_written), 32'(m_l1w));
            chk("rnd_aerr", 32'(addr_err), 32'(m_ae));
            chk("rnd_cerr", 32'(csel_err), 32'(m_ce));
            chk("rnd_run_done", 32'(run_done), 0);
        end
        hif.h_re = 1'b0;

        // Reset in the middle of a run
        exp_cd = l0_m[1];
        cwr = 1'b1; crd = 1'b1; csel = CSEL_L0; caddr_wr = 12'd1; caddr_rd = 12'd1;
        cdata_wr = 20'h0F0F0; ready = 1'b0; iaddr = 12'd10;
        cyc();
        l0_m[1] = 20'h0F0F0;
        chk("pre_rst_l0w", 32'(l0_written), 1);
        chk("pre_rst_cdata", 32'(cdata_rd), 32'(exp_cd));
        chk("pre_rst_idata", 32'(idata), 32'(img_m[10]));
        cwr = 1'b0; crd = 1'b0;
        reset = 1'b0;
        #2;
        chk_all_zero("rst_mid");
        cyc();
        reset = 1'b1;
        cyc();
        chk("post_rst_l0w", 32'(l0_written), 0);
        chk("post_rst_aerr", 32'(addr_err), 0);
        chk("post_rst_run_done", 32'(run_done), 0);
        chk("post_rst_idata", 32'(idata), 32'(img_m[10]));
        busy = 1'b0; ready = 1'b1;
        cyc();
        chk("post_rst_run_end", 32'(run_done), 1);
        cyc();
        hif.h_re = 1'b1; hif.h_sel = 2'd1; hif.h_addr = 12'd1;
        cyc();
        chk("post_rst_keep_rvalid", 32'(hif.h_rvalid), 1);
        chk("post_rst_keep_mem", 32'(hif.h_rdata), 32'(l0_m[1]));
        hif.h_re = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/conv_layer_mem.md
Name: conv_layer_mem

Overview:
- Synthesizable responder for the CONV accelerator's memory side: serves the image-input port (iaddr/idata) and the layer-memory port (cwr/crd/csel/caddr/cdata).
- Holds three banks: image (IMG), conv output (L0), max-pool output (L1).
- Adds a host load/readback port, usable only while CONV is idle, plus run-status flags. It replaces the behavioural memories of the simulation harness in FPGA/system builds.

Parameters:
- DW, 20, data word width.
- AW, 12, address width for all ports.
- IMG_DEPTH, 4096, image bank words (64x64).
- L0_DEPTH, 4096, layer-0 bank words.
- L1_DEPTH, 1024, layer-1 bank words (32x32).

Ports:
- clk in 1: sole clock, all state on rising edge.
- reset in 1: asynchronous, active-low; 0 clears all registers.
- busy in 1: CONV busy.
- ready in 1: host ready, passed to CONV by top level; used here for idata gating.
- iaddr in AW: image read address.
- idata out DW: image read data.
- cwr in 1: layer write strobe.
- caddr_wr in AW: layer write address.
- cdata_wr in DW: layer write data.
- crd in 1: layer read strobe.
- caddr_rd in AW: layer read address.
- cdata_rd out DW: layer read data.
- csel in 3: bank select; 3'b001 = L0, 3'b011 = L1.
- h_we in 1: host write.
- h_re in 1: host read.
- h_sel in 2: host bank; 0 = IMG, 1 = L0, 2 = L1, 3 = reserved.
- h_addr in AW: host address.
- h_wdata in DW: host write data.
- h_rdata out DW: host read data.
- h_rvalid out 1: host read data valid.
- h_err out 1: host access rejected (pulse).
- l0_written out 1: sticky, at least one L0 write this run.
- l1_written out 1: sticky, at least one L1 write this run.
- run_done out 1: one-cycle pulse on busy falling edge.
- addr_err out 1: sticky, out-of-range CONV access.
- csel_err out 1: sticky, cwr/crd with invalid csel.

Behaviour:
- Reset values: idata, cdata_rd, h_rdata = 0; h_rvalid, h_err, run_done, l0_written, l1_written, addr_err, csel_err = 0. Memory contents are not reset.
- idata latency 1 cycle:
  - edge N samples iaddr; idata = IMG[iaddr] after edge N.
  - Only when busy=1 and ready=0; otherwise idata <= 0.
  - iaddr >= IMG_DEPTH -> idata <= 0, addr_err set.
- Layer write: cwr=1 at an edge writes cdata_wr to bank(csel)[caddr_wr] at that edge.
- Layer read latency 1 cycle: crd=1 at edge N -> cdata_rd = bank(csel)[caddr_rd] after edge N. cdata_rd holds its value when crd=0.
- Same bank, same address, cwr and crd in the same cycle: read-first, cdata_rd returns the old word.
- Invalid csel with cwr or crd: write dropped, cdata_rd <= 0, csel_err set.
- Address >= bank depth (e.g. L1 addr 1024): write dropped, read returns 0, addr_err set.
- Status flags:
  - Edge detector on busy, registered previous-busy, reset value 0.
  - Rising edge clears l0_written, l1_written, addr_err, csel_err. Same-cycle set and clear: set wins.
  - Falling edge -> run_done pulses 1 cycle.
  - Valid L0/L1 write sets l0_written/l1_written.
- Host port (FSM states IDLE, RUN):
  - IDLE when busy=0; RUN when busy=1. Transitions follow the registered busy.
  - In IDLE: h_we writes bank(h_sel)[h_addr].
  - In IDLE: h_re -> h_rdata, h_rvalid=1 next cycle (latency 1); h_rvalid is a 1-cycle pulse.
  - h_we and h_re together: read-first, both performed.
  - h_sel=3 or out-of-range address: h_err pulses, no access, h_rvalid stays 0.
  - In RUN, any h_we/h_re: ignored, h_err pulses 1 cycle. CONV ports have exclusive access.
- Reset mid-run: registers clear immediately. Memory keeps partial contents. Previous-busy clears to 0, so a later busy=1 is treated as a new run start.
- Width: DW-bit words stored verbatim, no arithmetic.

Decomposition:
- Package conv_mem_pkg:
  - DW, AW, depth constants.
  - CSEL_L0=3'b001, CSEL_L1=3'b011.
  - Host select enum: HSEL_IMG, HSEL_L0, HSEL_L1.
  - FSM state enum: IDLE, RUN.
- One sub-module, conv_mem_bank: single-clock, one write port, one registered read-first read port, parameterised on depth. Instantiated three times; port muxing is in the top.

Test Plan:
- Host loads IMG[0..4095]=addr*3; busy=1, ready=0; iaddr sweep 0..4095 -> idata = 3*iaddr one cycle later. With ready=1 -> idata=0.
- cwr, csel=001, addr 5, data 20'hABCDE; next cycle crd addr 5 -> cdata_rd=20'hABCDE after that edge; l0_written=1; l1_written stays 0.
- Same cycle: cwr addr 7 data 20'h11111 and crd addr 7, old value 20'h22222, csel=011 -> cdata_rd=20'h22222; following read -> 20'h11111.
- csel=011 write to addr 1024 -> addr_err=1, L1 unchanged. csel=010 read -> cdata_rd=0, csel_err=1. Next busy rise clears both.
- busy=1, h_re=1 -> h_err pulse, h_rvalid=0. busy falls -> run_done one cycle. h_re L1 addr 3 -> h_rvalid with stored value.
- reset=0 mid-run while busy=1 -> all outputs 0 within the same cycle. Release with busy=1 -> treated as run start, flags remain 0.
